// File: rtl/fetch_align.sv
//==============================================================================
// Module      : fetch_align
// Description : Instruction fetch/align stage. Drives the slot pointer to the
//               instruction memory, selects the addressed 32-bit slot from the
//               returned pair word and skips zero padding slots. Presents one
//               instruction per handshake to decode. Handles branch/jump
//               redirects and halts after a run of padding slots.
//               Optional feature macro: FETCH_RVC_EN (compressed-instruction
//               detection and zero-extension of 16-bit instructions).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_align #(
   parameter int ZERO_RUN_HALT = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic [5:0]  PC_Sel,
   input  logic [63:0] IR,
   output logic [31:0] instr_out,
   output logic        instr_c,
   output logic [5:0]  instr_slot,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [5:0]  redirect_slot,
   output logic        halted
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   localparam logic [5:0] HALT_RUN = 6'(ZERO_RUN_HALT);

   logic [0:0]  state;
   logic [0:0]  state_nxt;
   logic [5:0]  pc;
   logic [5:0]  zrun;
   logic [5:0]  zrun_inc;
   logic [31:0] slot_word;
   logic [31:0] load_word;
   logic        load_c;
   logic        slot_zero;
   logic        le;
   logic        halt_hit;

   assign PC_Sel    = pc;
   // Even slot lives in the upper half of the pair word.
   assign slot_word = pc[0] ? IR[31:0] : IR[63:32];
   assign slot_zero = (slot_word == 32'h0000_0000);
   assign le        = !instr_valid || instr_ready;
   assign zrun_inc  = zrun + 6'd1;
   assign halt_hit  = (zrun_inc == HALT_RUN);

`ifdef FETCH_RVC_EN
   // Anything whose low two bits are not 2'b11 is a 16-bit compressed opcode.
   assign load_c    = (slot_word[1:0] != 2'b11);
   assign load_word = load_c ? {16'h0000, slot_word[15:0]} : slot_word;
`else
   assign load_c    = 1'b0;
   assign load_word = slot_word;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: redirect always returns to RUN; a long padding run halts.
   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = ST_RUN;
      end else if (state == ST_RUN && le && slot_zero && halt_hit) begin
         state_nxt = ST_HALT;
      end
   end

   // FSM outputs.
   always_comb begin
      halted = (state == ST_HALT);
   end

   // Slot pointer, padding counter and decode output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= 6'd0;
         zrun        <= 6'd0;
         instr_out   <= 32'h0000_0000;
         instr_c     <= 1'b0;
         instr_slot  <= 6'd0;
         instr_valid <= 1'b0;
      end else if (redirect_valid) begin
         // Any same-cycle handshake still completes; otherwise the held
         // instruction is simply dropped.
         pc          <= redirect_slot;
         zrun        <= 6'd0;
         instr_valid <= 1'b0;
      end else if (state == ST_RUN) begin
         if (le) begin
            pc <= pc + 6'd1;
            if (slot_zero) begin
               zrun        <= zrun_inc;
               instr_valid <= 1'b0;
            end else begin
               zrun        <= 6'd0;
               instr_out   <= load_word;
               instr_c     <= load_c;
               instr_slot  <= pc;
               instr_valid <= 1'b1;
            end
         end
      end else begin
         // HALT: only drain the pending instruction.
         if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_align.sv
//==============================================================================
// Module      : tb_fetch_align
// Description : Self-checking bench for fetch_align. A behavioural instruction
//               memory feeds the DUT; expected transfers are queued per test
//               and compared against transfers observed at the handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_align;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  PC_Sel;
   logic [63:0] IR;
   logic [31:0] instr_out;
   logic        instr_c;
   logic [5:0]  instr_slot;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [5:0]  redirect_slot;
   logic        halted;

   logic [31:0] mem [64];
   logic [38:0] exp_q[$];
   logic [38:0] obs_q[$];
   int tests = 0;
   int fails = 0;

   fetch_align #(.ZERO_RUN_HALT(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .PC_Sel         (PC_Sel),
      .IR             (IR),
      .instr_out      (instr_out),
      .instr_c        (instr_c),
      .instr_slot     (instr_slot),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_slot  (redirect_slot),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   // Instruction memory: pair word, even slot in the upper half.
   assign IR = {mem[{PC_Sel[5:1], 1'b0}], mem[{PC_Sel[5:1], 1'b1}]};

   // Record each transfer ahead of the edge that completes it.
   always @(negedge clk) begin
      if (reset && instr_valid && instr_ready)
         obs_q.push_back({instr_slot, instr_c, instr_out});
   end

   function automatic logic [38:0] exp_of(input logic [5:0] slot);
      logic [31:0] w;
      logic        c;
      logic [31:0] o;
      w = mem[slot];
`ifdef FETCH_RVC_EN
      c = (w[1:0] != 2'b11);
      o = c ? {16'h0000, w[15:0]} : w;
`else
      c = 1'b0;
      o = w;
`endif
      return {slot, c, o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_at(input logic [5:0] slot);
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_slot  = slot;
      tick();
      redirect_valid = 1'b0;
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [38:0] e;
      logic [38:0] o;
      reset = 1'b0;
      tick();
      tests++; if (PC_Sel !== 6'd0) begin fails++; $display("FAIL rst_pc: got %0d expected 0", PC_Sel); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
      tests++; if (instr_out !== 32'h0) begin fails++; $display("FAIL rst_out: got %h expected 0", instr_out); end
      tests++; if (instr_c !== 1'b0 || instr_slot !== 6'd0 || halted !== 1'b0) begin
         fails++; $display("FAIL rst_misc: c=%b slot=%0d halted=%b expected 0/0/0", instr_c, instr_slot, halted); end
      reset = 1'b1;
      instr_ready = 1'b1;
      exp_q.push_back(exp_of(6'd1));
      tests++; if (PC_Sel !== 6'd0) begin fails++; $display("FAIL first_pc0: got %0d expected 0", PC_Sel); end
      tick();
      tests++; if (PC_Sel !== 6'd1 || instr_valid !== 1'b0) begin
         fails++; $display("FAIL first_pc1: pc=%0d valid=%b expected 1/0", PC_Sel, instr_valid); end
      tick();
      e = exp_of(6'd1);
      tests++; if (PC_Sel !== 6'd2 || instr_valid !== 1'b1) begin
         fails++; $display("FAIL first_pc2: pc=%0d valid=%b expected 2/1", PC_Sel, instr_valid); end
      tests++; if ({instr_slot, instr_c, instr_out} !== e) begin
         fails++; $display("FAIL first_instr: got %h expected %h", {instr_slot, instr_c, instr_out}, e); end
      tick();
      tests++; if (obs_q.size() !== exp_q.size()) begin
         fails++; $display("FAIL first_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         tests++; if (o !== e) begin fails++; $display("FAIL first_xfer: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_skip();
      logic [38:0] e;
      logic [38:0] o;
      start_at(6'd12);
      instr_ready = 1'b1;
      exp_q.push_back(exp_of(6'd12));
      exp_q.push_back(exp_of(6'd14));
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_slot !== 6'd12) begin
         fails++; $display("FAIL skip_first: valid=%b slot=%0d expected 1/12", instr_valid, instr_slot); end
      tick();
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL skip_bubble: got valid=%b expected 0", instr_valid); end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_slot !== 6'd14 || instr_c !== 1'b0) begin
         fails++; $display("FAIL skip_second: valid=%b slot=%0d c=%b expected 1/14/0", instr_valid, instr_slot, instr_c); end
      tick(); tick();
      tests++; if (obs_q.size() !== exp_q.size()) begin
         fails++; $display("FAIL skip_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         tests++; if (o !== e) begin fails++; $display("FAIL skip_xfer: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_stall();
      logic [38:0] e;
      logic [38:0] o;
      start_at(6'd30);
      for (int i = 30; i < 34; i++) exp_q.push_back(exp_of(6'(i)));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (PC_Sel !== 6'd31 || instr_slot !== 6'd30 || instr_out !== mem[30] || instr_valid !== 1'b1) begin
            fails++; $display("FAIL stall_hold: pc=%0d slot=%0d out=%h valid=%b expected 31/30/%h/1",
                              PC_Sel, instr_slot, instr_out, instr_valid, mem[30]); end
      end
      instr_ready = 1'b1;
      tick();
      tests++; if (instr_slot !== 6'd31 || instr_valid !== 1'b1) begin
         fails++; $display("FAIL stall_resume: slot=%0d valid=%b expected 31/1", instr_slot, instr_valid); end
      tick(); tick(); tick(); tick();
      tests++; if (obs_q.size() !== exp_q.size()) begin
         fails++; $display("FAIL stall_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         tests++; if (o !== e) begin fails++; $display("FAIL stall_xfer: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_redirect();
      logic [38:0] e;
      logic [38:0] o;
      start_at(6'd20);
      exp_q.push_back(exp_of(6'd20));
      exp_q.push_back(exp_of(6'd25));
      instr_ready = 1'b1;
      tick();
      redirect_valid = 1'b1;
      redirect_slot  = 6'd25;
      tick();
      redirect_valid = 1'b0;
      tests++; if (instr_valid !== 1'b0 || PC_Sel !== 6'd25) begin
         fails++; $display("FAIL redir_next: valid=%b pc=%0d expected 0/25", instr_valid, PC_Sel); end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_slot !== 6'd25 || instr_out !== mem[25]) begin
         fails++; $display("FAIL redir_target: valid=%b slot=%0d out=%h expected 1/25/%h",
                           instr_valid, instr_slot, instr_out, mem[25]); end
      tick(); tick();
      tests++; if (obs_q.size() !== exp_q.size()) begin
         fails++; $display("FAIL redir_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         tests++; if (o !== e) begin fails++; $display("FAIL redir_xfer: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_halt();
      logic [38:0] e;
      logic [38:0] o;
      start_at(6'd40);
      instr_ready = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_early: got %b expected 0", halted); end
      tick();
      tests++; if (halted !== 1'b1 || instr_valid !== 1'b0 || PC_Sel !== 6'd48) begin
         fails++; $display("FAIL halt_enter: halted=%b valid=%b pc=%0d expected 1/0/48", halted, instr_valid, PC_Sel); end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (halted !== 1'b1 || PC_Sel !== 6'd48) begin
            fails++; $display("FAIL halt_hold: halted=%b pc=%0d expected 1/48", halted, PC_Sel); end
      end
      exp_q.push_back(exp_of(6'd1));
      redirect_valid = 1'b1;
      redirect_slot  = 6'd1;
      tick();
      redirect_valid = 1'b0;
      tests++; if (halted !== 1'b0 || PC_Sel !== 6'd1) begin
         fails++; $display("FAIL halt_exit: halted=%b pc=%0d expected 0/1", halted, PC_Sel); end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_slot !== 6'd1) begin
         fails++; $display("FAIL halt_resume: valid=%b slot=%0d expected 1/1", instr_valid, instr_slot); end
      tick();
      tests++; if (obs_q.size() !== exp_q.size()) begin
         fails++; $display("FAIL halt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         tests++; if (o !== e) begin fails++; $display("FAIL halt_xfer: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_wrap_reset();
      logic [38:0] e;
      logic [38:0] o;
      start_at(6'd63);
      exp_q.push_back(exp_of(6'd63));
      exp_q.push_back(exp_of(6'd0));
      instr_ready = 1'b1;
      tick();
      tests++; if (PC_Sel !== 6'd0 || instr_slot !== 6'd63) begin
         fails++; $display("FAIL wrap_pc: pc=%0d slot=%0d expected 0/63", PC_Sel, instr_slot); end
      tick();
      tests++; if (instr_slot !== 6'd0 || instr_valid !== 1'b1) begin
         fails++; $display("FAIL wrap_slot0: slot=%0d valid=%b expected 0/1", instr_slot, instr_valid); end
      tick();
      tests++; if (obs_q.size() !== exp_q.size()) begin
         fails++; $display("FAIL wrap_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         tests++; if (o !== e) begin fails++; $display("FAIL wrap_xfer: got %h expected %h", o, e); end
      end
      #3;
      reset = 1'b0;
      #1;
      tests++; if (PC_Sel !== 6'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
         fails++; $display("FAIL async_rst_ctl: pc=%0d valid=%b halted=%b expected 0/0/0", PC_Sel, instr_valid, halted); end
      tests++; if (instr_out !== 32'h0 || instr_c !== 1'b0 || instr_slot !== 6'd0) begin
         fails++; $display("FAIL async_rst_data: out=%h c=%b slot=%0d expected 0/0/0", instr_out, instr_c, instr_slot); end
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_slot  = 6'd0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0]  = 32'h0000_0000;
      mem[1]  = 32'h0000_40F9;
      mem[12] = 32'h41C2_5093;
      mem[14] = 32'h0032_0133;
      mem[20] = 32'h00C0_0293;
      mem[21] = 32'h00D0_0313;
      mem[25] = 32'h00E0_0393;
      mem[30] = 32'h00A0_0093;
      mem[31] = 32'h00B0_0113;
      mem[32] = 32'h0020_81B3;
      mem[33] = 32'h4011_0233;
      mem[63] = 32'h0010_0513;

      test_reset();
      test_skip();
      test_stall();
      test_redirect();
      test_halt();
      mem[0] = 32'h0000_4505;
      test_wrap_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_align.md
# fetch_align

Instruction fetch/align stage directly upstream of the instruction memory. Holds the slot pointer and drives the 6-bit slot select into the instruction memory. Receives the 64-bit pair word back, picks the addressed 32-bit slot, and skips zero padding slots. Presents one instruction per handshake to decode, with branch/jump redirect and a padding-run halt.

## Interface
Parameters:
- `ZERO_RUN_HALT`, default 8: number of consecutive zero slots skipped before entering HALT (valid range 1..63).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PC_Sel` out 6: slot index to the instruction memory. `PC_Sel[5:1]` selects the pair and `PC_Sel[0]` selects the slot within it.
- `IR` in 64: pair word from the instruction memory. `IR[63:32]` is the even slot and `IR[31:0]` is the odd slot. Combinational in `PC_Sel` within the same cycle.
- `instr_out` out 32: aligned instruction (compressed instructions are zero-extended from [15:0]).
- `instr_c` out 1: `instr_out` is a 16-bit compressed instruction.
- `instr_slot` out 6: slot index `instr_out` came from.
- `instr_valid` out 1: output register holds an instruction.
- `instr_ready` in 1: decode accepts; transfer occurs when `instr_valid && instr_ready`.
- `redirect_valid` in 1: branch/jump taken; restart fetch.
- `redirect_slot` in 6: target slot index.
- `halted` out 1: high in HALT state.

## Operation
- State: `pc` (6 b), `zrun` (6 b), output register {`instr_out`, `instr_c`, `instr_slot`, `instr_valid`}, and FSM {RUN, HALT}.
- `PC_Sel = pc` at all times. The current slot `s` is `IR[63:32]` when `pc[0]==0`, else `IR[31:0]`.
- "Load enable" `le = !instr_valid || instr_ready`.
- RUN, no redirect, with `le`:
  - If `s == 0`: the slot is padding. Set `pc <= pc+1` and `zrun <= zrun+1`, and clear `instr_valid` (the current instruction, if any, was consumed). If `zrun+1 == ZERO_RUN_HALT`, go to HALT.
  - If `s != 0`: load the output register from `s`, set `instr_slot <= pc`, `instr_valid <= 1`, `pc <= pc+1`, `zrun <= 0`.
- RUN without `le` (stall): all state holds and `PC_Sel` stays stable.
- HALT: `instr_valid` clears once the pending instruction is accepted. `pc` and `zrun` hold. Leaving HALT requires a redirect.
- Redirect has the highest priority in any state:
  - `pc <= redirect_slot`, `zrun <= 0`, `instr_valid <= 0`, state <= RUN.
  - If the same cycle has `instr_valid && instr_ready`, that transfer completes and is counted by decode.
  - If there is no handshake, the held instruction is discarded.
- Wrap-around: `pc` is modulo 64, so 63 increments to 0 with no flag.

## Timing
- Reset values:
  - `pc = 0`, `zrun = 0`, state RUN.
  - `instr_out = 0`, `instr_c = 0`, `instr_slot = 0`, `instr_valid = 0`, `halted = 0`.
  - `PC_Sel = 0`.
- Fetch-to-valid latency is 1 cycle: a non-zero slot at `pc` in cycle N gives `instr_valid` in cycle N+1.
- Sustained throughput is 1 instruction/cycle with `instr_ready` held high and no padding. Each padding slot costs 1 bubble cycle.
- Redirect in cycle N: `PC_Sel = redirect_slot` in N+1, with the first valid target instruction at N+2 if that slot is non-zero.
- Output register fields change only on load or redirect. They hold while `instr_valid && !instr_ready`.
- Reset asserted mid-operation immediately forces the reset values, including dropping `instr_valid` without a handshake.

## Configuration
- `FETCH_RVC_EN` defined:
  - `instr_c = (s[1:0] != 2'b11)`.
  - Compressed slots give `instr_out = {16'h0000, s[15:0]}`.
- `FETCH_RVC_EN` undefined:
  - `instr_c` is tied 0.
  - `instr_out = s` unmodified for every non-zero slot.
- Padding skip, HALT and redirect are identical in both builds.

## Test plan
- Reset, then slot0=0 and slot1=0x000040F9 with ready=1. Required: `PC_Sel` 0→1→2, and in cycle 2 `instr_valid=1`, `instr_out=0x000040F9`, `instr_c=1` (RVC build), `instr_slot=1`.
- Slots 12..14 = 0x41C25093, 0, 0x00320133 with ready=1 → two transfers (slots 12, 14) with one bubble; `instr_c=0` for both.
- Stall: ready=0 for 3 cycles while valid. Required: `PC_Sel`, `instr_out` and `instr_slot` stable; on ready=1 the next instruction follows 1 cycle later with none lost or duplicated.
- Redirect to slot 25 in the same cycle as an accepted transfer. Required: the transfer counts, the next cycle has valid=0 and `PC_Sel=25`, and slot 25's instruction is valid the cycle after.
- Eight consecutive zero slots (ZERO_RUN_HALT=8). Required: `halted=1`, valid=0, `PC_Sel` frozen; a redirect to 1 resumes RUN with `halted=0`.
- pc=63 non-zero, slot0 non-zero → transfers from slot 63 then slot 0. Then assert reset mid-stream → all outputs return to reset values asynchronously.
